// File: rtl/config_pkg.sv
// Shared state encoding and defaults for the config broadcaster.
// CONFIG_BCAST_CHECKSUM_EN enables the per-transfer checksum output.
package config_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUIESCE,
    S_SEND,
    S_GAP
  } bcast_state_t;

  localparam logic [7:0] CFG_IDLE_ID = 8'hFF;

  function automatic logic [7:0] sum8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/config_byte_fifo.sv
// Synchronous show-ahead byte FIFO with occupancy count and flush.
// Used by config_broadcaster (CONFIG_BCAST_CHECKSUM_EN has no effect here).
module config_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign w_wr    = i_push && (r_count < FULL);
  assign w_rd    = i_pop && (r_count != '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

endmodule

// File: rtl/config_broadcaster.sv
// Buffers config bytes and broadcasts them to one target block.
// Define CONFIG_BCAST_CHECKSUM_EN to add the cfg_checksum output.
module config_broadcaster
  import config_pkg::*;
#(
  parameter int unsigned MAX_BYTES      = 16,
  parameter int unsigned QUIESCE_CYCLES = 4,
  parameter logic [7:0]  IDLE_CONFIG_ID = CFG_IDLE_ID
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tracing_req,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [7:0] target_id,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef CONFIG_BCAST_CHECKSUM_EN
  ,
  output logic [7:0] cfg_checksum
`endif
);

  localparam int unsigned CW    = $clog2(MAX_BYTES) + 1;
  localparam logic [CW-1:0] FULL  = CW'(MAX_BYTES);
  localparam logic [15:0]   QLAST = 16'(QUIESCE_CYCLES - 1);

  bcast_state_t  r_state;
  logic [15:0]   r_qcnt;
  logic [CW-1:0] r_left;
  logic [7:0]    r_tgt;

  logic          w_start;
  logic          w_bad;
  logic          w_go;
  logic          w_push;
  logic          w_pop;
  logic          w_step;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_idle;

  assign w_start    = start_valid && start_ready;
  assign w_bad      = w_start && (target_id == IDLE_CONFIG_ID);
  assign w_go       = w_start && !w_bad;
  assign w_push     = wr_valid && wr_ready && !w_bad;
  assign w_step     = (r_state == S_SEND) ||
                      (r_state == S_QUIESCE && r_qcnt == '0);
  assign w_pop      = w_step && (r_left != '0);
  assign w_cnt_idle = w_bad ? '0 : w_count + CW'(w_push);

  config_byte_fifo #(
    .DEPTH (MAX_BYTES)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_bad),
    .i_wdata (wr_data),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_qcnt      <= '0;
      r_left      <= '0;
      r_tgt       <= IDLE_CONFIG_ID;
      tracing     <= 1'b0;
      configId    <= IDLE_CONFIG_ID;
      configData  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wr_ready    <= 1'b0;
      start_ready <= 1'b0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      configId   <= IDLE_CONFIG_ID;
      configData <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state     <= S_QUIESCE;
            r_qcnt      <= QLAST;
            r_left      <= w_count;
            r_tgt       <= target_id;
            tracing     <= 1'b0;
            busy        <= 1'b1;
            wr_ready    <= 1'b0;
            start_ready <= 1'b0;
          end else begin
            tracing     <= tracing_req;
            err         <= w_bad;
            wr_ready    <= (w_cnt_idle < FULL);
            start_ready <= 1'b1;
          end
        end
        S_QUIESCE, S_SEND: begin
          if (w_step) begin
            if (r_left != '0) begin
              r_state    <= S_SEND;
              configId   <= r_tgt;
              configData <= w_head;
              r_left     <= r_left - CW'(1);
            end else begin
              r_state <= S_GAP;
              done    <= 1'b1;
            end
          end else begin
            r_qcnt <= r_qcnt - 16'd1;
          end
        end
        S_GAP: begin
          r_state     <= S_IDLE;
          busy        <= 1'b0;
          tracing     <= tracing_req;
          wr_ready    <= (w_count < FULL);
          start_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CONFIG_BCAST_CHECKSUM_EN
  logic [7:0] r_acc;

  // Sum is published on GAP entry, so it holds until the next transfer ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      cfg_checksum <= '0;
    end else begin
      if (w_go)       r_acc <= '0;
      else if (w_pop) r_acc <= sum8(r_acc, w_head);
      if (w_step && r_left == '0) cfg_checksum <= r_acc;
    end
  end
`endif

endmodule

// File: tb/tb_config_broadcaster.sv
// Bench for config_broadcaster: timeline model plus directed literal checks.
// Checksum checks compile only with CONFIG_BCAST_CHECKSUM_EN defined.
`timescale 1ns/1ps
module tb_config_broadcaster;

  localparam int MAXB = 16;
  localparam int QC   = 4;
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tracing_req = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       start_valid = 1'b0;
  logic [7:0] target_id = '0;
  logic       wr_ready, start_ready, tracing, busy, done, err;
  logic [7:0] configId, configData;
`ifdef CONFIG_BCAST_CHECKSUM_EN
  logic [7:0] cfg_checksum;
`endif

  always #5 clk = ~clk;

  config_broadcaster #(
    .MAX_BYTES      (MAXB),
    .QUIESCE_CYCLES (QC),
    .IDLE_CONFIG_ID (IDLE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tracing_req  (tracing_req),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .target_id    (target_id),
    .tracing      (tracing),
    .configId     (configId),
    .configData   (configData),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef CONFIG_BCAST_CHECKSUM_EN
    ,
    .cfg_checksum (cfg_checksum)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a start expands into a per-cycle timeline of expected outputs.
  typedef struct {
    logic       trc;
    logic [7:0] id;
    logic [7:0] dat;
    logic       bsy;
    logic       dn;
    logic [7:0] ck;
  } ent_t;

  function automatic ent_t mk(input logic [7:0] id, input logic [7:0] dat,
                              input logic dn, input logic [7:0] ck);
    ent_t e;
    e.trc = 1'b0; e.id = id; e.dat = dat;
    e.bsy = 1'b1; e.dn = dn; e.ck = ck;
    return e;
  endfunction

  ent_t       plan[$];
  logic [7:0] mq[$];
  ent_t       m_e;
  logic [7:0] m_b, m_sum;
  int         m_len;
  logic       m_aw, m_as;
  logic       e_trc = 0, e_bsy = 0, e_dn = 0, e_err = 0, e_wr = 0, e_st = 0;
  logic [7:0] e_id = 8'hFF, e_dat = 0, e_ck = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); plan.delete();
      e_trc = 0; e_bsy = 0; e_dn = 0; e_err = 0; e_wr = 0; e_st = 0;
      e_id = IDLE; e_dat = 0; e_ck = 0;
    end else begin
      m_aw = wr_valid && e_wr;
      m_as = start_valid && e_st;
      e_err = 0;
      if (m_as && target_id == IDLE) begin
        mq.delete();
        e_err = 1;
      end else begin
        if (m_as) begin
          m_len = mq.size();
          m_sum = 0;
          for (int i = 0; i < QC; i++) plan.push_back(mk(IDLE, 8'h00, 0, 0));
          for (int i = 0; i < m_len; i++) begin
            m_b = mq.pop_front();
            m_sum = m_sum + m_b;
            plan.push_back(mk(target_id, m_b, 0, 0));
          end
          plan.push_back(mk(IDLE, 8'h00, 1, m_sum));
        end
        if (m_aw) mq.push_back(wr_data);
      end
      if (plan.size() > 0) begin
        m_e = plan.pop_front();
        e_trc = m_e.trc; e_id = m_e.id; e_dat = m_e.dat;
        e_bsy = m_e.bsy; e_dn = m_e.dn;
        e_wr = 0; e_st = 0;
        if (m_e.dn) e_ck = m_e.ck;
      end else begin
        e_trc = tracing_req; e_id = IDLE; e_dat = 0;
        e_bsy = 0; e_dn = 0;
        e_wr = (mq.size() < MAXB); e_st = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tracing", tracing, 0);
      chk("rst_configId", configId, IDLE);
      chk("rst_configData", configData, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_start_ready", start_ready, 0);
    end else begin
      chk("tracing", tracing, e_trc);
      chk("configId", configId, e_id);
      chk("configData", configData, e_dat);
      chk("busy", busy, e_bsy);
      chk("done", done, e_dn);
      chk("err", err, e_err);
      chk("wr_ready", wr_ready, e_wr);
      chk("start_ready", start_ready, e_st);
`ifdef CONFIG_BCAST_CHECKSUM_EN
      chk("cfg_checksum", cfg_checksum, e_ck);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_valid = 1; wr_data = b;
    tick(1);
    wr_valid = 0;
  endtask

  // Returns one step into cycle T+1 of the accepted start.
  task automatic go(input logic [7:0] t);
    start_valid = 1; target_id = t;
    tick(1);
    start_valid = 0;
  endtask

  int n;
  logic [7:0] last;

  initial begin
    tick(2);
    chk("lit_rst_wr_ready", wr_ready, 0);
    chk("lit_rst_configId", configId, 8'hFF);
`ifdef CONFIG_BCAST_CHECKSUM_EN
    chk("lit_rst_checksum", cfg_checksum, 0);
`endif
    rst = 0;
    tick(1);
    chk("lit_post_rst_wr_ready", wr_ready, 1);
    chk("lit_post_rst_start_ready", start_ready, 1);
    chk("lit_post_rst_tracing", tracing, 1);

    // three bytes to target 2
    wr(8'h01); wr(8'h02); wr(8'h03);
    go(8'h02);
    tick(3);
    chk("lit_t4_configId", configId, 8'hFF);
    chk("lit_t4_tracing", tracing, 0);
    tick(1);
    chk("lit_t5_configId", configId, 8'h02);
    chk("lit_t5_data", configData, 8'h01);
    tick(2);
    chk("lit_t7_data", configData, 8'h03);
    tick(1);
    chk("lit_t8_done", done, 1);
    chk("lit_t8_configId", configId, 8'hFF);
    tick(1);
    chk("lit_t9_busy", busy, 0);

    // fill to capacity, overflow byte dropped
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
    chk("lit_full_wr_ready", wr_ready, 0);
    wr(8'hEE);
    go(8'h05);
    n = 0; last = 0;
    for (int k = 0; k < 25; k++) begin
      if (configId == 8'h05) begin n++; last = configData; end
      tick(1);
    end
    chk("lit_full_len", n, 16);
    chk("lit_full_last", last, 8'h4F);

    // empty transfer
    go(8'h07);
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      if (configId == 8'h07) n++;
      if (k == 5) chk("lit_empty_done_t5", done, 1);
      if (k == 6) chk("lit_empty_tracing_t6", tracing, 1);
      tick(1);
    end
    chk("lit_empty_no_target", n, 0);
    tracing_req = 0; tick(1);
    chk("lit_trc_follow0", tracing, 0);
    tracing_req = 1; tick(1);
    chk("lit_trc_follow1", tracing, 1);

    // write and start in the same cycle
    wr(8'hAA); wr(8'hBB);
    wr_valid = 1; wr_data = 8'hCC; start_valid = 1; target_id = 8'h03;
    tick(1);
    wr_valid = 0; start_valid = 0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (configId == 8'h03) n++;
      tick(1);
    end
    chk("lit_same_cycle_len", n, 2);
    go(8'h04);
    tick(4);
    chk("lit_carry_configId", configId, 8'h04);
    chk("lit_carry_data", configData, 8'hCC);
    tick(1);
    chk("lit_carry_done", done, 1);
    tick(2);

    // reject on idle id
    wr(8'h11); wr(8'h22);
    go(8'hFF);
    chk("lit_rej_err", err, 1);
    chk("lit_rej_tracing", tracing, 1);
    chk("lit_rej_busy", busy, 0);
    tick(1);
    chk("lit_rej_err_pulse", err, 0);
    go(8'h09);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      if (configId == 8'h09) n++;
      if (k == 5) chk("lit_rej_flushed_done", done, 1);
      tick(1);
    end
    chk("lit_rej_flushed", n, 0);

    // reset during SEND
    for (int i = 0; i < 5; i++) wr(8'h61 + 8'(i));
    go(8'h06);
    tick(5);
    chk("lit_abort_send", configId, 8'h06);
    rst = 1;
    #1;
    chk("lit_abort_configId", configId, 8'hFF);
    chk("lit_abort_tracing", tracing, 0);
    chk("lit_abort_busy", busy, 0);
    tick(2);
    rst = 0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) n++;
      tick(1);
    end
    chk("lit_abort_no_done", n, 0);
    go(8'h08);
    tick(8);

`ifdef CONFIG_BCAST_CHECKSUM_EN
    wr(8'hF0); wr(8'h20);
    go(8'h01);
    tick(6);
    chk("lit_ck_done", done, 1);
    chk("lit_ck_value", cfg_checksum, 8'h10);
    tick(3);
    chk("lit_ck_hold", cfg_checksum, 8'h10);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/config_broadcaster.md
CONFIG_BROADCASTER -- requirements
Module: config_broadcaster

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16, meaning byte-buffer depth (power of two, >=2).
REQ-002 SHALL have parameter QUIESCE_CYCLES, default 4, meaning tracing-off cycles before the first config byte (>=1).
REQ-003 SHALL have parameter IDLE_CONFIG_ID, default 8'hFF, meaning the configId value that matches no block.
REQ-004 SHALL have one clock; reset is asynchronous and active-high: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-005 SHALL have ports: tracing_req input 1 host tracing enable; wr_valid input 1, wr_ready output 1, wr_data input 8 byte-load handshake.
REQ-006 SHALL have ports: start_valid input 1, start_ready output 1, target_id input 8 transfer-start handshake.
REQ-007 SHALL have outputs: tracing 1 global tracing enable; configId 8 target block id; configData 8 config byte; busy 1 transfer in progress; done 1 one-cycle completion pulse; err 1 one-cycle reject pulse.

Function
REQ-008 SHALL buffer bytes in a FIFO; wr_ready=1 only in IDLE with count<MAX_BYTES; a byte is accepted when wr_valid&&wr_ready.
REQ-009 SHALL assert start_ready=1 only in IDLE; a start is accepted when start_valid&&start_ready.
REQ-010 SHALL latch length L = FIFO count before the accept cycle's write; a byte accepted in the same cycle as start stays buffered for the next transfer.
REQ-011 SHALL implement FSM IDLE->QUIESCE->SEND->GAP->IDLE, with SEND skipped when L=0.
REQ-012 SHALL, for a start accepted at cycle T, drive tracing=0, configId=IDLE_CONFIG_ID in cycles T+1..T+QUIESCE_CYCLES.
REQ-013 SHALL, in SEND, drive configId=target_id and configData=byte k in cycle T+QUIESCE_CYCLES+1+k for k=0..L-1, in FIFO order, with no bubbles.
REQ-014 SHALL hold GAP for exactly one cycle with configId=IDLE_CONFIG_ID, configData=0, tracing=0, and done=1.
REQ-015 SHALL drive tracing=tracing_req (registered, 1-cycle delay) in IDLE, and tracing=0 in all other states.
REQ-016 SHALL drive busy=1 in QUIESCE, SEND and GAP, and busy=0 in IDLE.
REQ-017 SHALL, when target_id==IDLE_CONFIG_ID at start, not leave IDLE, flush the FIFO and pulse err for one cycle.
REQ-018 SHALL register all outputs; configData SHALL be 0 whenever configId==IDLE_CONFIG_ID.

Reset
REQ-019 SHALL, on rst (also mid-transfer), immediately force: state IDLE, FIFO empty, tracing=0, configId=IDLE_CONFIG_ID, configData=0, busy=0, done=0, err=0, wr_ready=0, start_ready=0.
REQ-020 SHALL resume normal IDLE behaviour on the first clock after rst deasserts; an aborted transfer is not resumed.

Configuration
REQ-021 SHALL, with CONFIG_BCAST_CHECKSUM_EN defined, provide output cfg_checksum[7:0] = modulo-256 sum of bytes sent in the last transfer, updated in the GAP cycle and 0 after reset.
REQ-022 SHALL, without CONFIG_BCAST_CHECKSUM_EN, omit the cfg_checksum port and its logic, with all other behaviour identical.

Structure
REQ-023 SHALL place the FSM state enum and IDLE_CONFIG_ID default in shared package config_pkg.
REQ-024 SHALL implement the byte buffer as sub-module config_byte_fifo (sync FIFO, MAX_BYTES deep, with count output).

Verification
REQ-025 SHALL cover: load 3 bytes 0x01,0x02,0x03, start target 2, QUIESCE_CYCLES=4 -> configId=2 in cycles T+5..T+7 with data 01,02,03, then GAP with done=1 at T+8 and busy=0 at T+9.
REQ-026 SHALL cover: 16 writes with MAX_BYTES=16 -> wr_ready=0 after 16th; 17th byte not stored; transfer sends exactly 16 bytes.
REQ-027 SHALL cover: start with empty FIFO -> no cycle with configId=target; done at T+5; tracing back to tracing_req at T+6/T+7.
REQ-028 SHALL cover: wr and start in same cycle with 2 bytes buffered -> 2 bytes sent; third byte sent by the next transfer.
REQ-029 SHALL cover: start with target_id=0xFF -> err pulse, FIFO empty, tracing never drops; and rst asserted during SEND -> configId=0xFF and tracing=0 immediately, no done.
REQ-030 SHALL cover, with CONFIG_BCAST_CHECKSUM_EN defined: bytes 0xF0,0x20 -> cfg_checksum=0x10 after GAP.
